pipe_stage_buffer: RTL and testbench
====================================

# pipe_stage_buffer

Parametrised elastic pipeline-stage buffer replacing fixed-width, lock-only inter-stage registers (IF/ID, ID/EX, …). It holds up to DEPTH in-flight entries of DATA_W payload plus a halted sideband, uses a valid/ready handshake on both sides, and supports a synchronous flush for branch/exception squash. It also latches a halt: once a halted instruction is accepted, no further instructions enter until flush or reset.

## Interface
- DATA_W, 32: payload width (instruction or bundled stage signals).
- DEPTH, 2: entry count, legal 1..4.
- BUBBLE, 32'h0000_0000 (sized to DATA_W): value driven on out_data whenever out_valid=0.
- clk  in  1  sole clock, rising edge.
- rst_b  in  1  reset; synchronous, active-high despite the name.
- flush  in  1  squash all held entries at next edge.
- in_valid  in  1  upstream offers in_data/in_halted.
- in_ready  out  1  buffer accepts this cycle.
- in_data  in  DATA_W  payload.
- in_halted  in  1  halt flag travelling with payload.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream consumes head.
- out_data  out  DATA_W  head payload, or BUBBLE.
- out_halted  out  1  head halt flag, 0 when !out_valid.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Circular store of DEPTH entries {data, halted}; write pointer, read pointer, count; pointers wrap at DEPTH-1 → 0.
- push = in_valid & in_ready & !flush; pop = out_valid & out_ready & !flush.
- in_ready = (count < DEPTH) & !halt_seen. Purely registered; no combinational path from out_ready or in_valid.
- Full plus pop: no pass-through; in_ready stays 0 that cycle and the entry frees at the edge.
- Push and pop in the same cycle (count between 1 and DEPTH-1): count unchanged and both pointers advance.
- halt_seen: set on the edge that pushes an entry with in_halted=1. While set, in_ready=0. Already-held entries keep draining normally.
- flush: at the next edge, count=0, pointers=0, halt_seen=0. It overrides any simultaneous push and pop, and nothing is consumed. in_ready may read 1 during the flush cycle, but the offered entry is discarded.
- out_valid = (count != 0); out_data/out_halted come from the read-pointer entry.
- rst_b takes precedence over flush. Reset mid-operation discards all contents with no drain.

## Timing
- Reset values: count=0, pointers=0, halt_seen=0, out_valid=0, out_data=BUBBLE, out_halted=0, in_ready=1.
- Latency: an entry pushed at edge N appears on out_* in the cycle after edge N (1 cycle).
- Throughput: DEPTH≥2 gives 1 entry/cycle sustained. DEPTH=1 gives at most 1 entry per 2 cycles under continuous flow, which is the legacy lock-register behaviour.
- A 1-cycle flush pulse causes out_valid=0 in the next cycle. A new push is possible in the cycle after flush.
- The halted entry is visible on out_halted in the same cycle as its data. out_halted never asserts with out_valid=0.

## Structure
- Shared package pipe_pkg:
  - NOP_BUBBLE constant (32'h0000_0000), used as the default for BUBBLE.
  - typedef pipe_entry_t {halted, data}, with DATA_W fixed per instance.
- Sub-module pipe_buf_ptr holds the write/read pointers and count.
  - Inputs: push, pop, clear.
  - Outputs: wr_ptr, rd_ptr, count, full, empty.
- Storage array and halt_seen stay in the top module.

## Test plan
- Reset then idle, DEPTH=2:
  - Assert rst_b 1 cycle → out_valid=0, out_data=0, count=0, in_ready=1.
- Streaming, DEPTH=2:
  - in_valid=1 with data 0x11, 0x22, 0x33…, out_ready=1 → out_data 0x11, 0x22, 0x33 on consecutive cycles, 1 cycle after each push; count stays 1.
- Backpressure, DEPTH=2:
  - out_ready=0, push 0xA1, 0xA2 → count=2, in_ready=0, 0xA3 held upstream.
  - out_ready=1 → 0xA1, 0xA2, 0xA3 emerge in order with no loss or duplication.
- Flush:
  - Hold 0xB1, 0xB2.
  - Assert flush with in_valid=1 and data 0xB3 → next cycle count=0, out_valid=0, out_data=BUBBLE; 0xB3 is never output.
- Halt:
  - Push 0xC1 with in_halted=1, then offer 0xC2 → in_ready=0 from the next cycle; 0xC1 exits with out_halted=1; 0xC2 is never accepted.
  - Then flush → in_ready=1 again.
- DEPTH=1 parameter variant:
  - Continuous in_valid with out_ready=1 → accept/emit alternate; in_ready toggles 1,0,1,0; out_valid never overlaps a push.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for elastic inter-stage pipeline buffers.
package pipe_pkg;

    localparam logic [31:0] NOP_BUBBLE  = 32'h0000_0000;
    localparam int unsigned PIPE_DATA_W = 32'd32;

    // Shape of one held entry for the standard 32-bit instruction path.
    typedef struct packed {
        logic                   halted;
        logic [PIPE_DATA_W-1:0] data;
    } pipe_entry_t;

    // A 1-entry buffer still needs a 1-bit pointer to keep ports legal.
    function automatic int unsigned ptr_width(input int unsigned depth);
        int unsigned w;
        if (depth > 32'd1) begin
            w = $clog2(depth);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pipe_buf_ptr.sv
// Read/write pointers and occupancy for the pipeline stage buffer.
module pipe_buf_ptr
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 32'd2,
    parameter int unsigned PTR_W = 32'd1,
    parameter int unsigned CNT_W = 32'd2
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_r;
    logic             empty_r;
    logic [PTR_W-1:0] wr_ptr_next_s;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [CNT_W-1:0] count_next_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(DEPTH - 32'd1)) begin
            r = '0;
        end else begin
            r = p + PTR_W'(1'b1);
        end
        return r;
    endfunction

    // Next-state pointers and occupancy from this cycle's push/pop.
    always_comb begin
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r;
        if (push) begin
            wr_ptr_next_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (pop) begin
            rd_ptr_next_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        case ({push, pop})
            2'b10:   count_next_s = count_r + CNT_W'(1'b1);
            2'b01:   count_next_s = count_r - CNT_W'(1'b1);
            default: count_next_s = count_r;
        endcase
    end

    // Full/empty are registered from the next count so in_ready is a flop output.
    always_ff @(posedge clk) begin
        if (rst_b || clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
            full_r   <= (count_next_s == CNT_W'(DEPTH));
            empty_r  <= (count_next_s == '0);
        end
    end

    assign wr_ptr = wr_ptr_r;
    assign rd_ptr = rd_ptr_r;
    assign count  = count_r;
    assign full   = full_r;
    assign empty  = empty_r;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic valid/ready inter-stage buffer with flush squash and halt latch.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W = 32'd32,
    parameter int unsigned       DEPTH  = 32'd2,
    parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(NOP_BUBBLE)
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_halted,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_halted,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 32'd1);
    localparam int unsigned SLOTS = 32'd1 << PTR_W;

    typedef struct packed {
        logic              halted;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           mem_r [SLOTS];
    logic             halt_seen_r;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic [PTR_W-1:0] wr_ptr_s;
    logic [PTR_W-1:0] rd_ptr_s;
    logic [CNT_W-1:0] count_s;

    // in_ready depends only on flops, never on out_ready, so a full buffer cannot pass through.
    assign in_ready  = !full_s && !halt_seen_r;
    assign out_valid = !empty_s;
    assign push_s    = in_valid && in_ready && !flush;
    assign pop_s     = out_valid && out_ready && !flush;
    assign count     = count_s;

    pipe_buf_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_ptr (
        .clk    (clk),
        .rst_b  (rst_b),
        .push   (push_s),
        .pop    (pop_s),
        .clear  (flush),
        .wr_ptr (wr_ptr_s),
        .rd_ptr (rd_ptr_s),
        .count  (count_s),
        .full   (full_s),
        .empty  (empty_s)
    );

    // Entry storage; contents need no reset because out_* are masked when empty.
    always_ff @(posedge clk) begin
        if (!rst_b && push_s) begin
            mem_r[wr_ptr_s] <= '{halted: in_halted, data: in_data};
        end
    end

    // Halt latch: blocks further intake until flush or reset.
    always_ff @(posedge clk) begin
        if (rst_b || flush) begin
            halt_seen_r <= 1'b0;
        end else if (push_s && in_halted) begin
            halt_seen_r <= 1'b1;
        end else begin
            halt_seen_r <= halt_seen_r;
        end
    end

    // Head entry presentation, bubble when nothing is held.
    always_comb begin
        out_data   = BUBBLE;
        out_halted = 1'b0;
        if (out_valid) begin
            out_data   = mem_r[rd_ptr_s].data;
            out_halted = mem_r[rd_ptr_s].halted;
        end else begin
            out_data   = BUBBLE;
            out_halted = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Scoreboard bench: DEPTH=2 main instance plus a DEPTH=1 instance with a non-zero bubble.
module tb_pipe_stage_buffer;

    localparam logic [31:0] BUB1 = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b, flush;
    logic        in_valid2, in_ready2, in_halted2, out_valid2, out_ready2, out_halted2;
    logic [31:0] in_data2, out_data2;
    logic [1:0]  count2;
    logic        in_valid1, in_ready1, in_halted1, out_valid1, out_ready1, out_halted1;
    logic [31:0] in_data1, out_data1;
    logic [0:0]  count1;

    int          errors = 0;
    int          checks = 0;
    logic [32:0] q2[$];
    logic [32:0] q1[$];

    pipe_stage_buffer #(.DATA_W(32), .DEPTH(2)) dut2 (
        .clk(clk), .rst_b(rst_b), .flush(flush),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_halted(in_halted2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_halted(out_halted2), .count(count2)
    );

    pipe_stage_buffer #(.DATA_W(32), .DEPTH(1), .BUBBLE(BUB1)) dut1 (
        .clk(clk), .rst_b(rst_b), .flush(flush),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_halted(in_halted1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_halted(out_halted1), .count(count1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one entry to dut2 and hold it until accepted (bounded).
    task automatic offer2(input logic [31:0] d, input logic h);
        bit got;
        got        = 1'b0;
        in_valid2  = 1'b1;
        in_data2   = d;
        in_halted2 = h;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready2) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL offer2_timeout: got in_ready=0 expected 1 for data %h", d);
        end
        step();
        in_valid2  = 1'b0;
        in_halted2 = 1'b0;
    endtask

    // dut2 monitor: pop-and-compare on consumption, then record accepted pushes.
    always @(negedge clk) begin : mon2
        logic [32:0] e;
        if (rst_b || flush) begin
            q2.delete();
        end else begin
            if (out_valid2 && out_ready2) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb2_unexpected: got %h expected no output", out_data2);
                end else begin
                    e = q2.pop_front();
                    chk("sb2_data", out_data2, e[31:0]);
                    chk("sb2_halted", 32'(out_halted2), 32'(e[32]));
                end
            end
            if (in_valid2 && in_ready2) q2.push_back({in_halted2, in_data2});
        end
        if (!out_valid2) begin
            chk("bubble2_data", out_data2, 32'h0000_0000);
            chk("bubble2_halted", 32'(out_halted2), 32'd0);
        end
    end

    // dut1 monitor, same scheme.
    always @(negedge clk) begin : mon1
        logic [32:0] e;
        if (rst_b || flush) begin
            q1.delete();
        end else begin
            if (out_valid1 && out_ready1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb1_unexpected: got %h expected no output", out_data1);
                end else begin
                    e = q1.pop_front();
                    chk("sb1_data", out_data1, e[31:0]);
                end
            end
            if (in_valid1 && in_ready1) q1.push_back({in_halted1, in_data1});
        end
        if (!out_valid1) chk("bubble1_data", out_data1, BUB1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] stream [4];
        logic        acc;
        stream = '{32'h11, 32'h22, 32'h33, 32'h44};
        rst_b = 1'b1; flush = 1'b0;
        in_valid2 = 1'b0; in_data2 = 32'h0; in_halted2 = 1'b0; out_ready2 = 1'b0;
        in_valid1 = 1'b0; in_data1 = 32'h0; in_halted1 = 1'b0; out_ready1 = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid2), 32'd0);
        chk("rst_out_data", out_data2, 32'h0);
        chk("rst_count", 32'(count2), 32'd0);
        chk("rst_in_ready", 32'(in_ready2), 32'd1);
        chk("rst_in_ready1", 32'(in_ready1), 32'd1);
        chk("rst_bubble1", out_data1, BUB1);
        step();
        rst_b = 1'b0;

        // Streaming: one per cycle, count holds at 1
        out_ready2 = 1'b1;
        step();
        in_valid2 = 1'b1;
        in_data2  = stream[0];
        step();
        for (int i = 1; i < 4; i++) begin
            in_data2 = stream[i];
            @(negedge clk);
            chk("stream_count", 32'(count2), 32'd1);
            chk("stream_in_ready", 32'(in_ready2), 32'd1);
            step();
        end
        in_valid2 = 1'b0;
        @(negedge clk);
        chk("stream_tail_data", out_data2, 32'h44);
        step();
        @(negedge clk);
        chk("stream_drained", 32'(count2), 32'd0);

        // Backpressure: full stalls the third entry
        step();
        out_ready2 = 1'b0;
        offer2(32'hA1, 1'b0);
        offer2(32'hA2, 1'b0);
        in_valid2 = 1'b1;
        in_data2  = 32'hA3;
        @(negedge clk);
        chk("bp_count_full", 32'(count2), 32'd2);
        chk("bp_in_ready", 32'(in_ready2), 32'd0);
        step();
        @(negedge clk);
        chk("bp_still_held", 32'(in_ready2), 32'd0);
        chk("bp_head", out_data2, 32'hA1);
        step();
        out_ready2 = 1'b1;
        offer2(32'hA3, 1'b0);
        repeat (3) step();
        @(negedge clk);
        chk("bp_drained", 32'(count2), 32'd0);

        // Flush from full with an offered entry
        step();
        out_ready2 = 1'b0;
        offer2(32'hB1, 1'b0);
        offer2(32'hB2, 1'b0);
        flush     = 1'b1;
        in_valid2 = 1'b1;
        in_data2  = 32'hB3;
        @(negedge clk);
        chk("flush_pre_count", 32'(count2), 32'd2);
        step();
        flush     = 1'b0;
        in_valid2 = 1'b0;
        @(negedge clk);
        chk("flush_count", 32'(count2), 32'd0);
        chk("flush_out_valid", 32'(out_valid2), 32'd0);
        chk("flush_out_data", out_data2, 32'h0);

        // Flush with in_ready=1: offered entry discarded, push right after flush works
        step();
        offer2(32'hD1, 1'b0);
        flush     = 1'b1;
        in_valid2 = 1'b1;
        in_data2  = 32'hD2;
        @(negedge clk);
        chk("flush2_in_ready", 32'(in_ready2), 32'd1);
        step();
        flush = 1'b0;
        offer2(32'hE1, 1'b0);
        @(negedge clk);
        chk("post_flush_count", 32'(count2), 32'd1);
        chk("post_flush_data", out_data2, 32'hE1);
        step();
        out_ready2 = 1'b1;
        repeat (2) step();

        // Halt latch
        out_ready2 = 1'b0;
        offer2(32'hC1, 1'b1);
        in_valid2  = 1'b1;
        in_data2   = 32'hC2;
        in_halted2 = 1'b0;
        @(negedge clk);
        chk("halt_in_ready", 32'(in_ready2), 32'd0);
        chk("halt_out_halted", 32'(out_halted2), 32'd1);
        chk("halt_out_data", out_data2, 32'hC1);
        chk("halt_count", 32'(count2), 32'd1);
        step();
        out_ready2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_blocks", 32'(in_ready2), 32'd0);
            step();
        end
        flush = 1'b1;
        step();
        flush     = 1'b0;
        in_valid2 = 1'b0;
        @(negedge clk);
        chk("halt_cleared", 32'(in_ready2), 32'd1);

        // Reset mid-operation discards contents
        step();
        out_ready2 = 1'b0;
        offer2(32'hF1, 1'b0);
        offer2(32'hF2, 1'b0);
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        @(negedge clk);
        chk("midrst_count", 32'(count2), 32'd0);
        chk("midrst_out_valid", 32'(out_valid2), 32'd0);
        step();
        out_ready2 = 1'b1;
        offer2(32'h5A, 1'b0);
        repeat (2) step();

        // DEPTH=1: accept and emit alternate
        out_ready1 = 1'b1;
        in_valid1  = 1'b1;
        in_data1   = 32'h100;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("d1_ready", 32'(in_ready1), (i % 2 == 0) ? 32'd1 : 32'd0);
            acc = in_ready1;
            if (acc) chk("d1_no_overlap", 32'(out_valid1), 32'd0);
            step();
            if (acc) in_data1 = in_data1 + 32'd1;
        end
        in_valid1 = 1'b0;
        repeat (3) step();

        @(negedge clk);
        chk("sb2_drained", 32'(q2.size()), 32'd0);
        chk("sb1_drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
